// File: rtl/reg_op_sequencer_pkg.sv
// Shared encodings for the register-operation sequencer: opcodes,
// register-block function selects and FSM states.
package reg_op_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_LOAD      = 3'b001,
        OP_CLEAR     = 3'b010,
        OP_INC_N     = 3'b011,
        OP_DEC_N     = 3'b100,
        OP_COPY      = 3'b101,
        OP_CLEAR_ALL = 3'b110,
        OP_RSVD      = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        FS_DEC   = 2'b00,
        FS_INC   = 2'b01,
        FS_LOAD  = 2'b10,
        FS_CLEAR = 2'b11
    } funsel_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_IDLE = 2'b01,
        ST_EXEC = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/reg_op_sequencer_register16bit.sv
// 16-bit register block controlled by enable E and function select
// FunSel (00 dec, 01 inc, 10 load I, 11 clear). No reset: contents are
// defined by the owner issuing a clear.
module Register16bit (
    input  logic        Clock,
    input  logic        E,
    input  logic [1:0]  FunSel,
    input  logic [15:0] I,
    output logic [15:0] Q
);

    logic [15:0] q_q;

    // Apply the selected function on enabled cycles; wraps modulo 2^16.
    always_ff @(posedge Clock) begin
        if (E) begin
            case (FunSel)
                2'b00:   q_q <= q_q - 16'd1;
                2'b01:   q_q <= q_q + 16'd1;
                2'b10:   q_q <= I;
                default: q_q <= 16'd0;
            endcase
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/reg_op_sequencer.sv
// Command sequencer driving a bank of four 16-bit registers.
// state | meaning
// INIT  | clear all four registers (one cycle after reset release)
// IDLE  | ready; accept and latch a command
// EXEC  | drive register enables for the latched command
// DONE  | one-cycle completion pulse; result visible on RdData
module reg_op_sequencer
    import reg_op_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [2:0]       CmdOp,
    input  logic [1:0]       CmdDst,
    input  logic [1:0]       CmdSrc,
    input  logic [CNT_W-1:0] CmdCount,
    input  logic [15:0]      CmdData,
    input  logic [1:0]       RdSel,
    output logic [15:0]      RdData,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    state_e           state_q, state_d;
    opcode_e          op_q, op_d;
    logic [1:0]       dst_q, dst_d;
    logic [1:0]       src_q, src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      data_q, data_d;

    logic [3:0]       reg_e;
    funsel_e          funsel;
    logic [15:0]      reg_in;
    logic [15:0]      reg_q [4];

    // State and latched-command registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_INIT;
            op_q    <= OP_NOP;
            dst_q   <= 2'd0;
            src_q   <= 2'd0;
            cnt_q   <= '0;
            data_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic and register-bank controls.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        reg_e   = 4'b0000;
        funsel  = FS_CLEAR;
        reg_in  = data_q;

        case (state_q)
            ST_INIT: begin
                // Gate with Reset so no register is enabled while reset is held.
                reg_e   = Reset ? 4'b0000 : 4'b1111;
                funsel  = FS_CLEAR;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (CmdValid) begin
                    op_d   = opcode_e'(CmdOp);
                    dst_d  = CmdDst;
                    src_d  = CmdSrc;
                    cnt_d  = CmdCount;
                    data_d = CmdData;
                    case (opcode_e'(CmdOp))
                        OP_NOP, OP_RSVD:    state_d = ST_DONE;
                        OP_INC_N, OP_DEC_N: state_d = (CmdCount == '0) ? ST_DONE : ST_EXEC;
                        default:            state_d = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                case (op_q)
                    OP_LOAD: begin
                        reg_e[dst_q] = 1'b1;
                        funsel       = FS_LOAD;
                    end
                    OP_CLEAR: begin
                        reg_e[dst_q] = 1'b1;
                        funsel       = FS_CLEAR;
                    end
                    OP_INC_N, OP_DEC_N: begin
                        reg_e[dst_q] = 1'b1;
                        funsel       = (op_q == OP_INC_N) ? FS_INC : FS_DEC;
                        cnt_d        = cnt_q - CNT_W'(1);
                        state_d      = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_EXEC;
                    end
                    OP_COPY: begin
                        reg_e[dst_q] = 1'b1;
                        funsel       = FS_LOAD;
                        reg_in       = reg_q[src_q];
                    end
                    OP_CLEAR_ALL: begin
                        reg_e  = 4'b1111;
                        funsel = FS_CLEAR;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_regs
        Register16bit u_reg (
            .Clock  (Clock),
            .E      (reg_e[g]),
            .FunSel (funsel),
            .I      (reg_in),
            .Q      (reg_q[g])
        );
    end

    assign CmdReady = (state_q == ST_IDLE);
    assign Busy     = (state_q != ST_IDLE);
    assign Done     = (state_q == ST_DONE);
    assign Err      = (state_q == ST_DONE) && (op_q == OP_RSVD);
    assign RdData   = reg_q[RdSel];

endmodule

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the repeat-count field.
REQ-002 SHALL have port Clock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port CmdValid  input  1  command present.
REQ-005 SHALL have port CmdReady  output  1  sequencer accepts a command this cycle.
REQ-006 SHALL have port CmdOp  input  3  opcode: 000 NOP, 001 LOAD, 010 CLEAR, 011 INC_N, 100 DEC_N, 101 COPY, 110 CLEAR_ALL, 111 reserved.
REQ-007 SHALL have port CmdDst  input  2  destination register index 0..3.
REQ-008 SHALL have port CmdSrc  input  2  source register index for COPY.
REQ-009 SHALL have port CmdCount  input  CNT_W  repeat count for INC_N/DEC_N.
REQ-010 SHALL have port CmdData  input  16  load value for LOAD.
REQ-011 SHALL have port RdSel  input  2  read-port register select.
REQ-012 SHALL have port RdData  output  16  combinational contents of register RdSel.
REQ-013 SHALL have port Busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port Done  output  1  one-cycle pulse on command completion.
REQ-015 SHALL have port Err  output  1  one-cycle pulse, coincident with Done, for reserved opcode.

Function
REQ-016 SHALL own a bank of four 16-bit registers, each driven only through E/FunSel/I (00 dec, 01 inc, 10 load, 11 clear).
REQ-017 SHALL implement FSM states INIT, IDLE, EXEC, DONE.
REQ-018 INIT SHALL last exactly one cycle, assert E on all four registers with FunSel=11, then go to IDLE.
REQ-019 CmdReady SHALL be high only in IDLE; a command is accepted on a rising edge with CmdValid and CmdReady both high.
REQ-020 On acceptance all Cmd* fields SHALL be latched; later input changes SHALL have no effect on the running command.
REQ-021 Accepted commands SHALL move IDLE->EXEC; when the final EXEC cycle ends, EXEC->DONE; DONE->IDLE after one cycle.
REQ-022 Done SHALL be high exactly in the DONE cycle, i.e. the first cycle in which the updated register value is visible on RdData.
REQ-023 LOAD: one EXEC cycle, Dst E=1, FunSel=10, I=latched data.
REQ-024 CLEAR: one EXEC cycle, Dst E=1, FunSel=11.
REQ-025 INC_N/DEC_N: Count EXEC cycles, Dst E=1, FunSel=01/00 each cycle; remaining-count register decrements each EXEC cycle.
REQ-026 INC_N/DEC_N with Count=0: zero register enables; IDLE->DONE directly.
REQ-027 Arithmetic SHALL be 16-bit modulo: 0xFFFF+1=0x0000, 0x0000-1=0xFFFF.
REQ-028 COPY: one EXEC cycle, Dst E=1, FunSel=10, I=register Src value; Src==Dst leaves the value unchanged.
REQ-029 CLEAR_ALL: one EXEC cycle, all four E=1, FunSel=11.
REQ-030 NOP and reserved: no register enables; IDLE->DONE directly; reserved also pulses Err.
REQ-031 Outside EXEC and INIT every register E SHALL be 0.
REQ-032 Latency from acceptance edge to Done: single-cycle ops 2 cycles; INC_N/DEC_N Count+1 cycles; NOP/Count=0 1 cycle.

Reset
REQ-033 Reset assertion SHALL force state INIT, Busy=1, CmdReady=0, Done=0, Err=0, all register E=0, remaining count 0, immediately and asynchronously.
REQ-034 Reset mid-command SHALL abort it without Done; register contents SHALL be cleared by the INIT cycle following Reset deassertion.
REQ-035 RdData SHALL be treated as undefined until the INIT cycle completes.

Structure
REQ-036 Opcode encodings, FunSel encodings and FSM state encodings SHALL reside in a shared package.
REQ-037 The four registers SHALL be instances of the existing 16-bit register block Register16bit; no other sub-module.

Verification
REQ-038 Reset released -> one INIT cycle, then all four RdData reads 0x0000, CmdReady=1.
REQ-039 LOAD Dst=2 Data=0xABCD -> Done 2 cycles after acceptance, RdSel=2 reads 0xABCD, other registers unchanged.
REQ-040 LOAD Dst=1 0xFFFE, INC_N Dst=1 Count=3 -> Done 4 cycles after acceptance, reads 0x0001; DEC_N Count=2 -> 0xFFFF.
REQ-041 LOAD R0=0x1234, COPY Src=0 Dst=3 -> R3=0x1234; COPY Src=3 Dst=3 -> R3 unchanged; CLEAR_ALL -> all 0x0000.
REQ-042 INC_N Count=0 and opcode 111 -> Done 1 cycle after acceptance, no register change, Err only for 111; CmdValid held during Busy -> no second acceptance.
REQ-043 Reset asserted mid INC_N Count=200 -> no Done, INIT follows release, all registers 0x0000, next command executes normally.
